arb_rr: RTL
===========

ARB_RR -- requirements
Module: arb_rr

Interface
- REQ-001: Parameter REQ_NUM, default 4; number of requesters. Legal values are powers of two, 2 to 16.
- REQ-002: Parameter KEY_WIDTH, default 2; width of o_key, equal to log2(REQ_NUM).
- REQ-003: i_clk  input  1  the single clock; all state changes on its rising edge.
- REQ-004: i_rst  input  1  reset; asynchronous, active-high.
- REQ-005: i_req  input  REQ_NUM  per-requester request, one bit per requester.
- REQ-006: i_last  input  REQ_NUM  per-requester last-beat flag; used only when ARB_RR_LOCK_EN is defined.
- REQ-007: i_ready  input  1  downstream consumer accepts the current grant.
- REQ-008: o_valid  output  1  a grant is being presented.
- REQ-009: o_gnt  output  REQ_NUM  one-hot grant; all zero when o_valid=0.
- REQ-010: o_key  output  KEY_WIDTH  binary index of the granted requester; drives the select key of the downstream 4-to-1 data mux.

Function
- REQ-011: State machine has two states. IDLE: o_valid=0. BUSY: o_valid=1.
- REQ-012: All outputs are registered; a request seen in IDLE produces o_valid=1 on the next rising edge (1-cycle latency).
- REQ-013: The priority pointer r_ptr is KEY_WIDTH bits wide. The grant selects the first asserted i_req at index r_ptr, r_ptr+1, ... in order, wrapping modulo REQ_NUM.
- REQ-014: IDLE with i_req=0: stay in IDLE, with o_gnt=0 and o_key=0.
- REQ-015: IDLE with any i_req set: go to BUSY, with o_gnt/o_key set to the selected requester.
- REQ-016: In BUSY, o_gnt and o_key are held stable until a handshake (o_valid && i_ready), except as stated in REQ-020.
- REQ-017: On handshake, r_ptr becomes (o_key+1) mod REQ_NUM; the wrap from REQ_NUM-1 goes to 0.
- REQ-018: On the handshake cycle, the next grant is arbitrated from the current i_req using the updated pointer.
  - If any request is present, stay in BUSY with the new grant, with no bubble.
  - Otherwise go to IDLE.
  - The just-served requester has the lowest priority.
- REQ-019: With i_ready held high and requests present, the block issues one grant per cycle.
- REQ-020: Withdrawal: in BUSY, if i_req[o_key]=0 and i_ready=0, go to IDLE on the next edge with r_ptr unchanged.
- REQ-021: Simultaneous withdrawal and handshake counts as a handshake (REQ-017/018 apply).
- REQ-022: o_gnt is always one-hot or zero, and o_gnt[o_key]=1 whenever o_valid=1.

Reset
- REQ-023: Asserting i_rst at any time, including mid-BUSY, immediately forces IDLE, r_ptr=0, o_valid=0, o_gnt=0, o_key=0.
- REQ-024: After i_rst deasserts, the first edge arbitrates normally from r_ptr=0.
- REQ-025: No handshake is reported for a grant that reset interrupted.

Configuration
- REQ-026: Macro ARB_RR_LOCK_EN controls burst locking.
- REQ-027: With ARB_RR_LOCK_EN defined, a handshake with i_last[o_key]=0 keeps the same grant in BUSY with r_ptr unchanged. Only a handshake with i_last[o_key]=1 applies REQ-017/018.
- REQ-028: With ARB_RR_LOCK_EN defined, withdrawal (REQ-020) still releases the lock.
- REQ-029: With ARB_RR_LOCK_EN undefined, i_last is ignored and every handshake releases the grant.

Verification
- REQ-030: Reset check: hold i_rst=1 with i_req=4'b1111 -> o_valid=0, o_gnt=0, o_key=0 throughout. Release i_rst -> next edge o_key=0.
- REQ-031: Single request: i_req=4'b0100, i_ready=1, from IDLE.
  - Next edge: o_valid=1, o_gnt=4'b0100, o_key=2.
  - Following edge: o_valid=0, r_ptr=3.
- REQ-032: Full rotation: i_req=4'b1111, i_ready=1 continuously -> o_key=0,1,2,3,0 on consecutive cycles, with no bubble.
- REQ-033: Backpressure: i_req=4'b0011, i_ready=0 for 3 cycles -> o_key=0 held stable. Raise i_ready -> next cycle o_key=1.
- REQ-034: Withdrawal: requester 0 granted, then i_req=4'b0010 with i_ready=0.
  - Next edge: o_valid=0.
  - Edge after: o_key=1, with r_ptr still 0 before that grant.
- REQ-035: Lock (ARB_RR_LOCK_EN defined): i_req=4'b0011, i_ready=1, i_last[0]=0,0,1 -> o_key=0 for 3 handshakes, then o_key=1. With the macro undefined -> o_key alternates 0,1.

Source files
------------

// File: rtl/arb_rr.sv
// Round-robin arbiter with registered grant/valid/key and a one-cycle request-to-grant latency.
// Define ARB_RR_LOCK_EN to hold a grant across handshakes until the granted requester flags i_last.
module arb_rr #(
  parameter int REQ_NUM   = 4,
  parameter int KEY_WIDTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [REQ_NUM-1:0]   i_req,
  input  logic [REQ_NUM-1:0]   i_last,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [REQ_NUM-1:0]   o_gnt,
  output logic [KEY_WIDTH-1:0] o_key
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

`ifdef ARB_RR_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  logic [0:0]           state_reg, state_next;
  logic [KEY_WIDTH-1:0] ptr_reg, ptr_next;
  logic [REQ_NUM-1:0]   gnt_reg, gnt_next;
  logic [KEY_WIDTH-1:0] key_reg, key_next;

  logic                 busy;
  logic                 handshake;
  logic                 last_key;
  logic                 lock_hold;
  logic                 release_gnt;
  logic                 withdraw;

  logic [KEY_WIDTH-1:0] arb_base;
  logic [KEY_WIDTH-1:0] arb_idx;
  logic [KEY_WIDTH-1:0] arb_sel;
  logic                 arb_found;

  assign busy        = (state_reg == ST_BUSY);
  assign handshake   = busy & i_ready;
  assign last_key    = i_last[key_reg];
  // Without locking, lock_hold folds to zero and every handshake releases.
  assign lock_hold   = LOCK_EN & handshake & ~last_key;
  assign release_gnt = handshake & ~lock_hold;
  assign withdraw    = busy & ~i_ready & ~i_req[key_reg];

  // In BUSY the arbiter is only consulted on release, where the search starts just past the served requester.
  assign arb_base = busy ? (key_reg + KEY_WIDTH'(1)) : ptr_reg;

  // Scan from the farthest offset down so the nearest asserted request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      arb_idx = arb_base + KEY_WIDTH'(k);
      if (i_req[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = arb_idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    key_next   = key_reg;
    case (state_reg)
      ST_IDLE: begin
        gnt_next = '0;
        key_next = '0;
        if (arb_found) begin
          state_next        = ST_BUSY;
          gnt_next[arb_sel] = 1'b1;
          key_next          = arb_sel;
        end
      end
      ST_BUSY: begin
        if (release_gnt) begin
          ptr_next = key_reg + KEY_WIDTH'(1);
          gnt_next = '0;
          key_next = '0;
          if (arb_found) begin
            gnt_next[arb_sel] = 1'b1;
            key_next          = arb_sel;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (withdraw) begin
          state_next = ST_IDLE;
          gnt_next   = '0;
          key_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        key_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      key_reg   <= key_next;
    end
  end

  assign o_valid = busy;
  assign o_gnt   = gnt_reg;
  assign o_key   = key_reg;

endmodule
